// File: rtl/cfg_pkg.sv
// Purpose: system-wide configuration constants shared across the stack subsystem.
package cfg_pkg;

    localparam int unsigned ENGS_N = 4;

endpackage : cfg_pkg

// File: rtl/stk_pkg.sv
// Purpose: stack pipe types and sizing shared by the writeback-side blocks.
package stk_pkg;

    typedef enum logic [1:0] {
        STS_OK  = 2'd0,
        STS_ERR = 2'd1,
        STS_TMO = 2'd2,
        STS_PAR = 2'd3
    } status_t;

    localparam int unsigned STATUS_W          = $bits(status_t);
    localparam int unsigned STK_RSP_Q_DEPTH_N = 4;
    localparam int unsigned RSP_DAT_W         = 128;

    // Response entry at the default data width.
    typedef struct packed {
        logic [RSP_DAT_W-1:0] dat;
        status_t              status;
    } rsp_ent_t;

endpackage : stk_pkg

// File: rtl/stk_rsp_fifo.sv
// Purpose: one engine's response queue: storage, wrap-bit pointers, full/empty, credit flop.
// Ports:
//   clk, arst_n          clock, async active-low reset
//   i_push               write request from writeback (already one-hot qualified)
//   i_dat, i_status      entry payload
//   o_vld, i_rdy         head valid / consume handshake
//   o_dat, o_status      head payload (valid while o_vld)
//   o_cred_rtn           one-cycle pulse the cycle after each pop
//   o_ovf_c              push arrived while full with no pop (combinational)
module stk_rsp_fifo #(
    parameter int unsigned DEPTH_N = 4,
    parameter int unsigned DAT_W   = 128,
    parameter int unsigned STS_W   = 2
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             i_push,
    input  logic [DAT_W-1:0] i_dat,
    input  logic [STS_W-1:0] i_status,
    output logic             o_vld,
    input  logic             i_rdy,
    output logic [DAT_W-1:0] o_dat,
    output logic [STS_W-1:0] o_status,
    output logic             o_cred_rtn,
    output logic             o_ovf_c
);

    localparam int unsigned IDX_W = $clog2(DEPTH_N);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned ENT_W = DAT_W + STS_W;

    logic [ENT_W-1:0] mem_q [DEPTH_N];
    logic [ENT_W-1:0] mem_d [DEPTH_N];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             cred_q, cred_d;

    logic empty, full, pop, push_ok;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign pop     = ~empty & i_rdy;
    // A pop in the same cycle frees the slot, so a push to a full queue still lands.
    assign push_ok = i_push & (~full | pop);
    assign o_ovf_c = i_push & full & ~pop;

    // Next-state for storage, pointers and credit.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        cred_d   = pop;
        if (push_ok) begin
            mem_d[wr_ptr_q[IDX_W-1:0]] = {i_dat, i_status};
        end
    end

    // Control state; reset discards contents and any pending credit.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cred_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cred_q   <= cred_d;
        end
    end

    // Payload storage needs no reset: it is only observed behind o_vld.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign o_vld             = ~empty;
    assign {o_dat, o_status} = mem_q[rd_ptr_q[IDX_W-1:0]];
    assign o_cred_rtn        = cred_q;

endmodule : stk_rsp_fifo

// File: rtl/stk_rsp_q.sv
// Purpose: per-engine response queues behind the non-stallable stack writeback,
//          with credit return to admission and sticky error flags.
// Ports:
//   clk, arst_n                      clock, async active-low reset
//   i_rsp_vld/dat/status             one-hot (or zero) writeback response
//   o_eng_rsp_vld/dat/status, i_eng_rsp_rdy   per-engine head valid/ready channel
//   o_cred_rtn                       per-engine credit pulse, one per pop
//   o_err_ovf, o_err_mhot            sticky: push to full queue / multi-hot valid
//   o_busy                           any queue non-empty
module stk_rsp_q
    import stk_pkg::*;
#(
    parameter int unsigned ENGS_N  = cfg_pkg::ENGS_N,
    parameter int unsigned DEPTH_N = STK_RSP_Q_DEPTH_N,
    parameter int unsigned DAT_W   = 128
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic [ENGS_N-1:0]          i_rsp_vld,
    input  logic [DAT_W-1:0]           i_rsp_dat,
    input  logic [STATUS_W-1:0]        i_rsp_status,
    output logic [ENGS_N-1:0]          o_eng_rsp_vld,
    input  logic [ENGS_N-1:0]          i_eng_rsp_rdy,
    output logic [ENGS_N*DAT_W-1:0]    o_eng_rsp_dat,
    output logic [ENGS_N*STATUS_W-1:0] o_eng_rsp_status,
    output logic [ENGS_N-1:0]          o_cred_rtn,
    output logic                       o_err_ovf,
    output logic                       o_err_mhot,
    output logic                       o_busy
);

    logic              mhot_c;
    logic [ENGS_N-1:0] push;
    logic [ENGS_N-1:0] ovf_c;
    logic              err_ovf_q, err_ovf_d;
    logic              err_mhot_q, err_mhot_d;

    // More than one bit set: clearing the lowest set bit leaves something behind.
    assign mhot_c = |(i_rsp_vld & (i_rsp_vld - ENGS_N'(1)));
    assign push   = i_rsp_vld & {ENGS_N{~mhot_c}};

    for (genvar e = 0; e < ENGS_N; e++) begin : g_eng
        stk_rsp_fifo #(
            .DEPTH_N (DEPTH_N),
            .DAT_W   (DAT_W),
            .STS_W   (STATUS_W)
        ) u_fifo (
            .clk        (clk),
            .arst_n     (arst_n),
            .i_push     (push[e]),
            .i_dat      (i_rsp_dat),
            .i_status   (i_rsp_status),
            .o_vld      (o_eng_rsp_vld[e]),
            .i_rdy      (i_eng_rsp_rdy[e]),
            .o_dat      (o_eng_rsp_dat[e*DAT_W +: DAT_W]),
            .o_status   (o_eng_rsp_status[e*STATUS_W +: STATUS_W]),
            .o_cred_rtn (o_cred_rtn[e]),
            .o_ovf_c    (ovf_c[e])
        );
    end

    // Sticky error accumulation.
    always_comb begin
        err_ovf_d  = err_ovf_q | (|ovf_c);
        err_mhot_d = err_mhot_q | mhot_c;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            err_ovf_q  <= 1'b0;
            err_mhot_q <= 1'b0;
        end else begin
            err_ovf_q  <= err_ovf_d;
            err_mhot_q <= err_mhot_d;
        end
    end

    assign o_err_ovf  = err_ovf_q;
    assign o_err_mhot = err_mhot_q;
    assign o_busy     = |o_eng_rsp_vld;

endmodule : stk_rsp_q

// File: tb/tb_stk_rsp_q.sv
// Scoreboard bench for stk_rsp_q: stimulus pushes expected entries, a negedge
// monitor checks heads, credits, busy and error flags against the model.
module tb_stk_rsp_q;
    import stk_pkg::*;

    localparam int unsigned EN = 4;
    localparam int unsigned DW = 128;
    localparam int unsigned SW = STATUS_W;
    localparam int          DEPTH = 4;

    logic                clk;
    logic                arst_n;
    logic [EN-1:0]       i_rsp_vld;
    logic [DW-1:0]       i_rsp_dat;
    logic [SW-1:0]       i_rsp_status;
    logic [EN-1:0]       o_eng_rsp_vld;
    logic [EN-1:0]       i_eng_rsp_rdy;
    logic [EN*DW-1:0]    o_eng_rsp_dat;
    logic [EN*SW-1:0]    o_eng_rsp_status;
    logic [EN-1:0]       o_cred_rtn;
    logic                o_err_ovf;
    logic                o_err_mhot;
    logic                o_busy;

    stk_rsp_q dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .i_rsp_vld        (i_rsp_vld),
        .i_rsp_dat        (i_rsp_dat),
        .i_rsp_status     (i_rsp_status),
        .o_eng_rsp_vld    (o_eng_rsp_vld),
        .i_eng_rsp_rdy    (i_eng_rsp_rdy),
        .o_eng_rsp_dat    (o_eng_rsp_dat),
        .o_eng_rsp_status (o_eng_rsp_status),
        .o_cred_rtn       (o_cred_rtn),
        .o_err_ovf        (o_err_ovf),
        .o_err_mhot       (o_err_mhot),
        .o_busy           (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rsp_ent_t      sb [EN][$];
    logic [EN-1:0] exp_cred = '0;
    logic          exp_ovf  = 1'b0;
    logic          exp_mhot = 1'b0;
    int            n_vec = 0;
    int            n_chk = 0;
    int            n_err = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic [EN-1:0] hs;
        rsp_ent_t      ent;
        if (!arst_n) begin
            chk("rst_vld",  DW'(o_eng_rsp_vld), DW'(0));
            chk("rst_cred", DW'(o_cred_rtn),    DW'(0));
            chk("rst_busy", DW'(o_busy),        DW'(0));
            chk("rst_ovf",  DW'(o_err_ovf),     DW'(0));
            chk("rst_mhot", DW'(o_err_mhot),    DW'(0));
            exp_cred = '0;
        end else begin
            hs = '0;
            for (int e = 0; e < EN; e++) begin
                chk($sformatf("vld%0d", e),  DW'(o_eng_rsp_vld[e]), DW'(sb[e].size() != 0));
                chk($sformatf("cred%0d", e), DW'(o_cred_rtn[e]),    DW'(exp_cred[e]));
            end
            chk("busy",     DW'(o_busy),     DW'(sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size() != 0));
            chk("err_ovf",  DW'(o_err_ovf),  DW'(exp_ovf));
            chk("err_mhot", DW'(o_err_mhot), DW'(exp_mhot));
            for (int e = 0; e < EN; e++) begin
                hs[e] = o_eng_rsp_vld[e] & i_eng_rsp_rdy[e];
                if (hs[e] && sb[e].size() != 0) begin
                    ent = sb[e].pop_front();
                    chk($sformatf("dat%0d", e), o_eng_rsp_dat[e*DW +: DW], ent.dat);
                    chk($sformatf("sts%0d", e), DW'(o_eng_rsp_status[e*SW +: SW]), DW'(ent.status));
                end
            end
            exp_cred = hs;
        end
    end

    // One cycle of writeback input; model updates land right after the edge.
    task automatic step(input logic [EN-1:0] vld, input logic [DW-1:0] dat, input status_t sts);
        logic [EN-1:0] acc;
        logic          ovf;
        logic          mh;
        acc = '0;
        ovf = 1'b0;
        mh  = ($countones(vld) > 1);
        i_rsp_vld    = vld;
        i_rsp_dat    = dat;
        i_rsp_status = sts;
        for (int e = 0; e < EN; e++) begin
            if (vld[e] && !mh) begin
                if (sb[e].size() < DEPTH || i_eng_rsp_rdy[e]) acc[e] = 1'b1;
                else                                          ovf    = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        for (int e = 0; e < EN; e++) begin
            if (acc[e]) sb[e].push_back('{dat: dat, status: sts});
        end
        if (ovf) exp_ovf  = 1'b1;
        if (mh)  exp_mhot = 1'b1;
        i_rsp_vld = '0;
        n_vec++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, STS_OK);
    endtask

    initial begin
        arst_n        = 1'b0;
        i_rsp_vld     = '0;
        i_rsp_dat     = '0;
        i_rsp_status  = '0;
        i_eng_rsp_rdy = '0;
        repeat (2) @(negedge clk);
        #2 arst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(3);

        // Single response on engine 1.
        i_eng_rsp_rdy = 4'b0010;
        step(4'b0010, DW'(128'hA5), STS_OK);
        idle(3);

        // Fill engine 0, then overflow, then drain in order.
        i_eng_rsp_rdy = 4'b0000;
        for (int i = 1; i <= 4; i++) step(4'b0001, DW'(i), STS_ERR);
        step(4'b0001, DW'(5), STS_TMO);
        idle(1);
        i_eng_rsp_rdy = 4'b0001;
        idle(6);

        // Full engine 2 with simultaneous pop and push.
        i_eng_rsp_rdy = 4'b0000;
        for (int i = 0; i < 4; i++) step(4'b0100, DW'(32'h10 + i), STS_OK);
        i_eng_rsp_rdy = 4'b0100;
        step(4'b0100, DW'(128'h55), STS_PAR);
        i_eng_rsp_rdy = 4'b0000;
        idle(2);
        i_eng_rsp_rdy = 4'b0100;
        idle(6);

        // Streaming through engine 3 across pointer wrap.
        i_eng_rsp_rdy = 4'b1000;
        for (int i = 0; i < 10; i++) step(4'b1000, DW'(i), status_t'(i % 4));
        idle(3);
        chk("busy_after_wrap", DW'(o_busy), DW'(0));

        // Multi-hot is dropped, later one-hot still works; all engines ready.
        i_eng_rsp_rdy = 4'b1111;
        step(4'b0101, DW'(128'h77), STS_ERR);
        step(4'b0001, DW'(128'h88), STS_OK);
        step(4'b0010, {64'hDEAD_BEEF_0123_4567, 64'h89AB_CDEF_FEDC_BA98}, STS_TMO);
        idle(3);

        // Async reset with three entries held in engine 0.
        i_eng_rsp_rdy = 4'b0000;
        for (int i = 0; i < 3; i++) step(4'b0001, DW'(32'hC0 + i), STS_OK);
        #2 arst_n = 1'b0;
        #1;
        chk("arst_vld",  DW'(o_eng_rsp_vld), DW'(0));
        chk("arst_busy", DW'(o_busy),        DW'(0));
        chk("arst_ovf",  DW'(o_err_ovf),     DW'(0));
        chk("arst_mhot", DW'(o_err_mhot),    DW'(0));
        for (int e = 0; e < EN; e++) sb[e].delete();
        exp_ovf  = 1'b0;
        exp_mhot = 1'b0;
        repeat (2) @(negedge clk);
        #2 arst_n = 1'b1;
        @(posedge clk);
        #1;
        i_eng_rsp_rdy = 4'b1111;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_stk_rsp_q

// File: doc/stk_rsp_q.md
Name: stk_rsp_q

Overview:
- Per-engine response queue directly downstream of the stack pipe writeback stage.
- Captures the fire-and-forget one-hot response (valid, 128b data, status) and buffers it in a per-engine FIFO.
- Presents each engine a valid/ready response channel and returns one credit per dequeued entry to the issue/admission logic.
- Together with the credits, this guarantees the non-stallable writeback never overflows.

Parameters:
- ENGS_N, cfg_pkg::ENGS_N (4), number of engines/queues.
- DEPTH_N, 4, entries per engine queue; power of two, >= 2.
- DAT_W, 128, response data width.

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- i_rsp_vld  in  ENGS_N  one-hot (or zero) response valid from writeback
- i_rsp_dat  in  DAT_W  response data
- i_rsp_status  in  $bits(stk_pkg::status_t)  response status
- o_eng_rsp_vld  out  ENGS_N  per-engine head valid
- i_eng_rsp_rdy  in  ENGS_N  per-engine consume
- o_eng_rsp_dat  out  ENGS_N*DAT_W  per-engine head data, engine e at [e*DAT_W +: DAT_W]
- o_eng_rsp_status  out  ENGS_N*$bits(status_t)  per-engine head status
- o_cred_rtn  out  ENGS_N  one-cycle credit-return pulse per engine
- o_err_ovf  out  1  sticky: push to a full queue
- o_err_mhot  out  1  sticky: i_rsp_vld multi-hot
- o_busy  out  1  any queue non-empty

Behaviour:
- Reset (arst_n low, async): all queues empty; o_eng_rsp_vld=0, o_cred_rtn=0, o_err_ovf=0, o_err_mhot=0, o_busy=0. Data/status outputs are don't-care while vld=0.
- Reset mid-operation discards all entries with no credit pulses. Upstream admission resets on the same arst_n.
- Push: i_rsp_vld[e]=1 writes {dat,status} at wr_ptr[e]; wr_ptr increments.
- Latency: push in cycle N -> o_eng_rsp_vld[e]=1 in cycle N+1. No combinational path from i_rsp_* to any output.
- Pop: o_eng_rsp_vld[e] & i_eng_rsp_rdy[e] in cycle N -> rd_ptr increments -> o_cred_rtn[e]=1 in cycle N+1 (registered, exactly one pulse per pop).
- Back-to-back pops with rdy held high deliver one entry per cycle.
- Head data is stable while vld=1 and rdy=0.
- Pointers: log2(DEPTH_N)+1 bits with wrap bit.
  - empty = (wr==rd).
  - full = MSBs differ and LSBs equal.
  - Wrap-around is natural modulo-2*DEPTH_N arithmetic.
- Queue not full: push accepted.
- Full, pop same cycle: push accepted; occupancy unchanged.
- Full, no pop: push dropped, o_err_ovf set (sticky until reset), state unchanged.
- Empty with push same cycle: no pop possible; entry visible next cycle. There is no bypass.
- Multi-hot i_rsp_vld: no queue written; o_err_mhot set sticky.
- Queues are fully independent: simultaneous pop on several engines yields simultaneous credit pulses.
- o_busy = OR of all non-empty flags (registered-state derived).

Decomposition:
- stk_pkg: status_t (existing) and STK_RSP_Q_DEPTH_N = 4.
- cfg_pkg: ENGS_N (existing).
- Sub-module stk_rsp_fifo holds one engine queue: storage, pointers, full/empty, credit flop.
  - Instantiated ENGS_N times in a generate loop.
  - Top level owns the one-hot check, error flops and o_busy.

Test Plan:
- Single response: i_rsp_vld=4'b0010, dat=128'hA5, status=OK in cycle 10; eng1 rdy=1 -> o_eng_rsp_vld=4'b0010 in cycle 11 with dat A5; o_cred_rtn=4'b0010 in cycle 12 only.
- Fill/overflow: 4 pushes to eng0 with rdy=0 -> full; 5th push -> dropped, o_err_ovf=1. Then 4 pops return data 1,2,3,4 in order with 4 credit pulses.
- Full with simultaneous pop: eng2 holds 4 entries, push 0x55 while popping -> occupancy stays 4; 0x55 delivered 4th.
- Wrap: push/pop 10 entries through eng3 at 1/cycle with rdy high -> in-order data 0..9, 10 credits, o_busy=0 at end.
- Multi-hot: i_rsp_vld=4'b0101 -> no queue changes, o_err_mhot=1; a subsequent valid one-hot push still works.
- Reset mid-op: 3 entries in eng0, assert arst_n=0 asynchronously -> outputs 0 immediately; after release vld=0 and no credit pulses.
